// File: rtl/fft_pkg.sv
// Shared types and helpers for the UART-to-FFT sample loader: state encoding,
// bytes-per-sample derivation, timeout product and index bit reversal.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FULL    = 2'd3
  } state_t;

  localparam int DEF_T_1_BIT      = 5207;
  localparam int DEF_BIT_WIDTH    = 29;
  localparam int DEF_TIMEOUT_BITS = 20;

  function automatic int calc_bps(input int bw);
    return (bw + 7) / 8;
  endfunction

  function automatic logic [31:0] calc_tmo(input int t_bit, input int n_bits);
    return 32'(t_bit * n_bits);
  endfunction

  localparam int          BPS = calc_bps(DEF_BIT_WIDTH);
  localparam logic [31:0] TMO = calc_tmo(DEF_T_1_BIT, DEF_TIMEOUT_BITS);

  // Reverses the low 'size' bits of idx; bits at and above 'size' come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] idx, input int size);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < size) r[size - 1 - i] = idx[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_uart_sample_loader_byte_assembler.sv
// Little-endian byte lane assembler with an inter-byte timeout that discards a
// partially received sample.
module byte_assembler #(
  parameter int          BPS = 4,
  parameter int          BW  = 29,
  parameter logic [31:0] TMO = 32'd200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic          word_ready,
  output logic [BW-1:0] word,
  output logic          timeout
);

  localparam int              CW        = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [CW-1:0]   LAST_LANE = CW'(BPS - 1);

  logic [8*BPS-1:0] shift_q;
  logic [8*BPS-1:0] word_next;
  logic [CW-1:0]    byte_cnt;
  logic [31:0]      tmo_cnt;
  logic             take;

  // Lane 0 starts a fresh sample, so stale upper lanes are cleared with it.
  always_comb begin
    word_next = (byte_cnt == '0) ? '0 : shift_q;
    word_next[8*int'(byte_cnt) +: 8] = rx_byte;
  end

  assign take       = en && rx_valid;
  assign word_ready = take && (byte_cnt == LAST_LANE);
  assign timeout    = !rx_valid && (byte_cnt != '0) && (tmo_cnt == TMO - 32'd1);
  assign word       = word_next[BW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      byte_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (take) begin
      shift_q  <= word_next;
      tmo_cnt  <= '0;
      byte_cnt <= word_ready ? '0 : byte_cnt + 1'b1;
    end else if (byte_cnt != '0) begin
      if (timeout) begin
        byte_cnt <= '0;
        tmo_cnt  <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/fft_uart_sample_loader.sv
// Assembles UART bytes into samples, writes them to FFT memory at bit-reversed
// addresses, and holds off after a full frame until the FFT reports done.
module fft_uart_sample_loader
  import fft_pkg::*;
#(
  parameter int t_1_bit      = 5207,
  parameter int bit_width    = 29,
  parameter int N            = 16,
  parameter int SIZE         = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  input  logic                 fft_done,
  output logic                 wr_en,
  output logic [SIZE-1:0]      wr_addr,
  output logic [bit_width-1:0] wr_data,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 drop,
  output state_t               state_dbg
);

  localparam int              BYTES    = calc_bps(bit_width);
  localparam logic [31:0]     TMO_CLKS = calc_tmo(t_1_bit, TIMEOUT_BITS);
  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte is
  // either consumed by the assembler the cycle it appears or reported via drop.
  state_t                 state_q, state_d;
  logic [SIZE-1:0]        sample_idx;
  logic                   last_q;
  logic                   asm_en;
  logic                   word_ready;
  logic                   timeout;
  logic [bit_width-1:0]   word;

  // The write cycle of the final sample already belongs to the held-off frame.
  assign asm_en = (state_q != FULL) && !(state_q == WRITE && last_q);

  byte_assembler #(
    .BPS (BYTES),
    .BW  (bit_width),
    .TMO (TMO_CLKS)
  ) u_byte_assembler (
    .clk        (clk),
    .rst        (rst_n),
    .en         (asm_en),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .word_ready (word_ready),
    .word       (word),
    .timeout    (timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (word_ready)    state_d = WRITE;
        else if (rx_valid) state_d = COLLECT;
      end
      COLLECT: begin
        if (word_ready)   state_d = WRITE;
        else if (timeout) state_d = IDLE;
      end
      WRITE: begin
        if (last_q)          state_d = FULL;
        else if (word_ready) state_d = WRITE;
        else if (rx_valid)   state_d = COLLECT;
        else                 state_d = IDLE;
      end
      FULL: begin
        if (fft_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Address and index advance on the completing byte so wr_en lands one cycle later.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      sample_idx <= '0;
      last_q     <= 1'b0;
    end else begin
      wr_en      <= word_ready;
      frame_done <= (state_q == WRITE) && last_q;
      if (word_ready) begin
        wr_addr    <= SIZE'(bit_reverse(32'(sample_idx), SIZE));
        wr_data    <= word;
        last_q     <= (sample_idx == LAST_IDX);
        sample_idx <= (sample_idx == LAST_IDX) ? '0 : sample_idx + 1'b1;
      end
    end
  end

  assign busy      = (state_q == FULL);
  assign drop      = rx_valid && !asm_en;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fft_uart_sample_loader.sv
// Randomized scoreboard bench for fft_uart_sample_loader with a queue-based
// reference model of framing, timeout and hold-off behaviour.
module tb_fft_uart_sample_loader;
  import fft_pkg::*;

  localparam int N    = 16;
  localparam int SIZE = 4;
  localparam int BW   = 29;
  localparam int T1   = 10;
  localparam int TB   = 20;
  localparam int TMOC = T1 * TB;
  localparam int EW   = 32 + SIZE + BW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_byte = 8'h00;
  logic            fft_done = 1'b0;
  logic            wr_en;
  logic [SIZE-1:0] wr_addr;
  logic [BW-1:0]   wr_data;
  logic            frame_done;
  logic            busy;
  logic            drop;
  state_t          state_dbg;

  fft_uart_sample_loader #(
    .t_1_bit      (T1),
    .bit_width    (BW),
    .N            (N),
    .SIZE         (SIZE),
    .TIMEOUT_BITS (TB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .fft_done   (fft_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .busy       (busy),
    .drop       (drop),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  int            fd_q[$];
  int            drop_q[$];

  logic [7:0]      part_q[$];
  int              m_idx = 0;
  bit              m_full = 1'b0;
  int              last_cyc = 0;
  logic [SIZE-1:0] hold_addr = '0;
  logic [BW-1:0]   hold_data = '0;
  logic [EW-1:0]   e;
  int              ec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int rev_idx(input int i);
    int r = 0;
    for (int k = 0; k < SIZE; k++) r = (r << 1) | ((i >> k) & 1);
    return r;
  endfunction

  // Reference model: bytes gather little-endian in groups of four; a gap longer
  // than TMOC clocks forgets a partial group; a full frame rejects bytes.
  task automatic model_byte(input logic [7:0] b);
    logic [31:0]   w;
    logic [BW-1:0] d;
    if (m_full) begin
      drop_q.push_back(cyc);
    end else begin
      if (part_q.size() != 0 && (cyc - last_cyc) > TMOC) part_q.delete();
      part_q.push_back(b);
      last_cyc = cyc;
      if (part_q.size() == 4) begin
        w = {part_q[3], part_q[2], part_q[1], part_q[0]};
        d = w[BW-1:0];
        exp_q.push_back({32'(cyc + 1), SIZE'(rev_idx(m_idx)), d});
        part_q.delete();
        m_idx++;
        if (m_idx == N) begin
          m_idx  = 0;
          m_full = 1'b1;
          fd_q.push_back(cyc + 2);
        end
      end
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    m_idx     = 0;
    m_full    = 1'b0;
    hold_addr = '0;
    hold_data = '0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
          check("wr_addr", 64'(wr_addr), 64'(e[BW +: SIZE]));
          check("wr_data", 64'(wr_data), 64'(e[BW-1:0]));
          hold_addr = e[BW +: SIZE];
          hold_data = e[BW-1:0];
        end
      end else begin
        check("hold_addr", 64'(wr_addr), 64'(hold_addr));
        check("hold_data", 64'(wr_data), 64'(hold_data));
      end
      if (frame_done) begin
        if (fd_q.size() == 0) check("unexpected_frame_done", 64'd1, 64'd0);
        else begin
          ec = fd_q.pop_front();
          check("frame_done_cycle", 64'(cyc), 64'(ec));
        end
      end
      if (drop) begin
        if (drop_q.size() == 0) check("unexpected_drop", 64'd1, 64'd0);
        else begin
          ec = drop_q.pop_front();
          check("drop_cycle", 64'(cyc), 64'(ec));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      rx_valid = 1'b0;
      fft_done = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit done);
    tick();
    rx_valid = 1'b1;
    rx_byte  = b;
    fft_done = done;
    model_byte(b);
    if (done) m_full = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int j = 0; j < 4; j++) begin
      send_byte(w[8*j +: 8], 1'b0);
      if (gap > 1) idle(gap - 1);
    end
  endtask

  task automatic send_rand(input int gap);
    send_word($urandom, gap);
  endtask

  task automatic done_only();
    tick();
    rx_valid = 1'b0;
    fft_done = 1'b1;
    m_full   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_drop"}, 64'(drop), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 rst_n = 1'b1;
    idle(3);
    check_zero("reset");
    rst_n = 1'b0;
    idle(2);

    send_word(32'h12345678, 5);
    send_word(32'hFFFFFFFF, 3);
    send_rand(2);
    send_rand(4);
    idle(2);

    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    idle(100);
    done_only();
    idle(149);
    send_word(32'h44332211, 3);
    idle(2);

    for (int i = 0; i < 11; i++) send_rand($urandom_range(1, 6));
    idle(4);
    check("busy_first_frame", 64'(busy), 64'd1);
    done_only();
    idle(1);
    check("busy_after_done", 64'(busy), 64'd0);

    for (int i = 0; i < 16; i++) send_rand(1);
    idle(4);
    check("busy_back_to_back", 64'(busy), 64'd1);

    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b0);
      idle(1);
    end
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(1);
    check("busy_after_drop_done", 64'(busy), 64'd0);

    for (int i = 0; i < 7; i++) send_rand($urandom_range(1, 4));
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b0);
    idle(3);

    tick();
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    fft_done = 1'b0;
    #1;
    check_zero("mid_reset");
    model_reset();
    idle(2);
    rst_n = 1'b0;
    idle(2);
    send_rand(3);
    for (int i = 0; i < 4; i++) send_rand($urandom_range(1, 6));
    idle(10);

    check("pending_writes", 64'(exp_q.size()), 64'd0);
    check("pending_frame_done", 64'(fd_q.size()), 64'd0);
    check("pending_drops", 64'(drop_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_uart_sample_loader.md
Name: fft_uart_sample_loader

Overview:
- Write-side counterpart of the FFT output path.
- Takes bytes from the UART receiver and assembles them little-endian into bit_width-bit complex-free real samples.
- Writes each sample into FFT working memory at the bit-reversed sample index. After N samples it pulses frame_done, the FFT start flag.
- Holds off further writes until the FFT core signals fft_done.

Parameters:
- t_1_bit, 5207, clocks per UART bit; used only for the inter-byte timeout.
- bit_width, 29, sample width written to memory.
- N, 16, samples per frame.
- SIZE, 4, log2(N) and the address width.
- TIMEOUT_BITS, 20, inter-byte gap limit in bit times. Timeout = TIMEOUT_BITS*t_1_bit clocks.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-high reset. Port name kept for codebase consistency; asserted = 1.
- rx_valid  in  1  one-cycle strobe: rx_byte is valid.
- rx_byte  in  8  received byte.
- fft_done  in  1  one-cycle pulse from the FFT/output path; frame consumed, memory free.
- wr_en  out  1  memory write strobe, one cycle per sample.
- wr_addr  out  SIZE  bit-reversed sample index.
- wr_data  out  bit_width  assembled sample.
- frame_done  out  1  one-cycle pulse after the Nth write.
- busy  out  1  high while a full frame awaits fft_done.
- drop  out  1  one-cycle pulse when a received byte is discarded.

Behaviour:
- Constants: BPS = ceil(bit_width/8), which is 4 at the default. TMO = TIMEOUT_BITS*t_1_bit.
- Reset (async, active-high): state=IDLE; byte_cnt=0, sample_idx=0, tmo_cnt=0, shift reg=0. All outputs 0.
- IDLE: rx_valid loads rx_byte into byte lane 0, sets byte_cnt=1 and goes to COLLECT. If BPS==1, it goes directly to WRITE.
- COLLECT:
  - rx_valid places the byte in lane byte_cnt and increments byte_cnt; tmo_cnt clears on every byte.
  - When the byte making byte_cnt==BPS arrives, go to WRITE.
  - With no byte, tmo_cnt increments. At tmo_cnt==TMO-1 the partial sample is discarded: byte_cnt=0, go to IDLE, sample_idx unchanged, no drop pulse.
- WRITE (exactly one cycle):
  - wr_en=1. wr_data = assembled word truncated to the low bit_width bits; upper bits are ignored.
  - wr_addr = bit-reverse(sample_idx) over SIZE bits.
  - Latency: last byte strobe at cycle T gives wr_en at T+1.
  - If sample_idx==N-1, go to FULL and reset sample_idx to 0. Otherwise increment sample_idx and go to IDLE.
  - An rx_valid during WRITE starts the next sample (lane 0, byte_cnt=1, next state COLLECT); no byte is lost.
- FULL:
  - frame_done=1 on the first FULL cycle only (T+2 relative to the last byte). busy=1 throughout FULL.
  - Every rx_valid gives drop=1 for that cycle; the byte is ignored.
  - fft_done leads to IDLE next cycle with busy=0. If fft_done and rx_valid coincide, the byte is dropped (drop=1).
- fft_done outside FULL is ignored.
- wr_addr/wr_data are held at their last written values when wr_en=0. They are registered outputs.
- Reset asserted mid-frame discards everything. The next frame restarts at index 0.

Decomposition:
- Shared package, fft_pkg:
  - function bit_reverse(idx, SIZE);
  - localparam BPS derivation;
  - state encoding constants IDLE/COLLECT/WRITE/FULL;
  - the TMO product, as a 32-bit constant.
- One natural sub-module: byte_assembler, covering the lane shift register, byte_cnt and timeout counter. It outputs word_ready and word.
- Top level holds the FSM, sample_idx and bit-reversal.

Test Plan:
- Test configuration for all scenarios: N=16, SIZE=4, bit_width=29, t_1_bit=10, TIMEOUT_BITS=20, so TMO=200 clocks.
- Bytes 78,56,34,12 (hex), one every 5 clocks -> wr_en one cycle after the last strobe; wr_data=0x12345678; wr_addr=0.
- Samples 1, 3 and 15 -> wr_addr=8, 12 and 15. Byte pattern FF,FF,FF,FF -> wr_data=0x1FFFFFFF.
- Two bytes, then a 250-clock gap, then 11,22,33,44 -> one write, wr_data=0x44332211, same index as before the gap; no drop.
- 64 bytes back-to-back (rx_valid every cycle) -> 16 writes in bit-reversed order 0,8,4,12,...,15. frame_done pulses once, 2 cycles after byte 64. busy=1 afterwards.
- In FULL, send 3 bytes then fft_done coincident with a 4th byte -> 4 drop pulses. busy falls the cycle after fft_done. The next sample writes to addr 0.
- Assert rst_n after 7 samples plus 2 bytes -> all outputs 0 immediately. The next complete sample writes to addr 0.
